// File: rtl/hx8352_reader.sv
// hx8352_reader: 8080-style register/GRAM read on the shared 16-bit HX8352 bus.
// Writes the index with RS=0 and a WR pulse, releases the bus, then issues
// one RD strobe per word (plus an optional leading dummy read). Every output
// is registered; the output registers are loaded from the next-state value so
// that they line up with the state they describe.
module hx8352_reader #(
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int TURN_CYC    = 2,
  parameter int RD_LOW_CYC  = 8,
  parameter int RD_HIGH_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  read_count,
  input  logic        dummy_read,
  output logic        busy,
  output logic        done,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        lcd_cs,
  output logic        lcd_rs,
  output logic        lcd_wr,
  output logic        lcd_rd,
  inout  wire  [15:0] data_bus
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD_WR_LOW,
    CMD_WR_HIGH,
    TURN,
    RD_LOW,
    RD_HIGH,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;      // cycles spent in the current state
  logic [8:0]      reads_q, reads_d;  // reads still to strobe; 9 bits holds 255+1
  logic [15:0]     addr_q, addr_d;
  logic            dummy_q, dummy_d;  // next read to complete is the dummy one
  logic            bus_oe;
  logic [15:0]     bus_q;
  logic            capture;

  // Bus is driven only while the index is on it; otherwise released to the panel.
  assign data_bus = bus_oe ? bus_q : 16'hzzzz;

  // Last RD-low cycle: the edge ending it samples the panel's data.
  assign capture = (state_q == RD_LOW) && (cnt_q == CW'(RD_LOW_CYC - 1));

  // State, phase counter and latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      reads_q <= '0;
      addr_q  <= '0;
      dummy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reads_q <= reads_d;
      addr_q  <= addr_d;
      dummy_q <= dummy_d;
    end
  end

  // Next-state logic: each timed state runs its cycle count, then moves on.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    reads_d = reads_q;
    addr_d  = addr_q;
    dummy_d = dummy_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          addr_d  = reg_addr;
          reads_d = {1'b0, read_count} + {8'd0, dummy_read};
          dummy_d = dummy_read;
          state_d = CMD_WR_LOW;
        end
      end
      CMD_WR_LOW: begin
        if (cnt_q == CW'(WR_LOW_CYC - 1)) begin
          cnt_d   = '0;
          state_d = CMD_WR_HIGH;
        end
      end
      CMD_WR_HIGH: begin
        if (cnt_q == CW'(WR_HIGH_CYC - 1)) begin
          cnt_d   = '0;
          state_d = (reads_q == '0) ? DONE : TURN;
        end
      end
      TURN: begin
        if (cnt_q == CW'(TURN_CYC - 1)) begin
          cnt_d   = '0;
          state_d = RD_LOW;
        end
      end
      RD_LOW: begin
        if (capture) begin
          cnt_d   = '0;
          reads_d = reads_q - 1'b1;
          dummy_d = 1'b0;
          state_d = RD_HIGH;
        end
      end
      RD_HIGH: begin
        if (cnt_q == CW'(RD_HIGH_CYC - 1)) begin
          cnt_d   = '0;
          state_d = (reads_q == '0) ? DONE : RD_LOW;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Registered pin and status outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_cs     <= 1'b1;
      lcd_rs     <= 1'b1;
      lcd_wr     <= 1'b1;
      lcd_rd     <= 1'b1;
      bus_oe     <= 1'b0;
      bus_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      lcd_cs     <= !(state_d inside {CMD_WR_LOW, CMD_WR_HIGH, TURN, RD_LOW, RD_HIGH});
      lcd_rs     <= !(state_d inside {CMD_WR_LOW, CMD_WR_HIGH});
      lcd_wr     <= (state_d != CMD_WR_LOW);
      lcd_rd     <= (state_d != RD_LOW);
      bus_oe     <= (state_d inside {CMD_WR_LOW, CMD_WR_HIGH});
      bus_q      <= addr_d;
      busy       <= !(state_d inside {IDLE, DONE});
      done       <= (state_d == DONE);
      data_valid <= capture && !dummy_q;
      if (capture && !dummy_q) begin
        data_out <= data_bus;
      end
    end
  end

endmodule
